// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned ID_W    = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface rr_arbiter8_if;
  import rr_arb_pkg::*;

  logic               arb_en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;

  modport master (
    output arb_en,
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid
  );

  modport slave (
    input  arb_en,
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid
  );

endinterface

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module onehot_dec3
  import rr_arb_pkg::*;
(
  input  logic [ID_W-1:0]    idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter over eight level-sensitive requesters with a per-ownership hold limit.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic         clk,
  input logic         rst_n,
  rr_arbiter8_if.slave bus
);

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  arb_state_e      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] owner;
  logic [7:0]      hold_cnt;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
  function automatic logic [ID_W-1:0] pick_owner(logic [NUM_REQ-1:0] r, logic [ID_W-1:0] p);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_W-1:0]      idx;
    dbl = {r, r} >> p;
    rot = dbl[NUM_REQ-1:0];
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = ID_W'(i);
    end
    return idx + p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.arb_en && (|bus.req)) begin
            owner    <= pick_owner(bus.req, ptr);
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Release and timeout on the same edge collapse into one release.
          if (!bus.req[owner] || (hold_cnt == HoldLast)) begin
            state <= IDLE;
            ptr   <= owner + 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_valid = (state == GRANT);
  assign bus.gnt_id    = owner;

  onehot_dec3 u_gnt_dec (
    .idx    (owner),
    .en     (bus.gnt_valid),
    .onehot (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with a per-cycle reference model of the grant rules.
module tb_rr_arbiter8;

  localparam int MaxHold = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(MaxHold)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: owner is -1 when nobody holds the grant; cnt counts grant cycles seen so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  function automatic int first_from(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_cnt   <= 0;
    end else if (m_owner < 0) begin
      if (bus.arb_en && bus.req != 8'h00) begin
        m_owner <= first_from(bus.req, m_ptr);
        m_cnt   <= 1;
      end
    end else if (!bus.req[m_owner] || m_cnt == MaxHold) begin
      m_owner <= -1;
      m_ptr   <= (m_owner + 1) % 8;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    e = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    check("model_gnt", 32'(bus.gnt), 32'(e));
    check("model_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) check("model_id", 32'(bus.gnt_id), 32'(m_owner[2:0]));
    check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
    if (bus.gnt_valid) check("gnt_at_id", 32'(bus.gnt[bus.gnt_id]), 32'd1);
  end

  // Step to just after the next falling edge, clear of the model compare.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [7:0] g, input int id);
    check({name, "_gnt"}, 32'(bus.gnt), 32'(g));
    check({name, "_valid"}, 32'(bus.gnt_valid), 32'(g != 8'h00));
    if (g != 8'h00) check({name, "_id"}, 32'(bus.gnt_id), 32'(id));
  endtask

  int order [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    rst_n      = 1'b0;
    bus.arb_en = 1'b0;
    bus.req    = 8'h00;
    tick(1);
    lit("reset", 8'h00, 0);
    check("reset_id", 32'(bus.gnt_id), 32'd0);

    // Basic grant, release and turnaround.
    rst_n      = 1'b1;
    bus.arb_en = 1'b1;
    bus.req    = 8'b0000_0101;
    tick(1); lit("first", 8'h01, 0);
    bus.req = 8'b0000_0100;
    tick(1); lit("release", 8'h00, 0);
    tick(1); lit("second", 8'h04, 2);
    bus.req = 8'h00;
    tick(1); lit("idle", 8'h00, 0);

    // Full rotation under constant load from a fresh reset.
    rst_n = 1'b0;
    #1;
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      for (int c = 0; c < MaxHold; c++) begin
        tick(1); lit("rr_hold", 8'(1 << order[i]), order[i]);
      end
      if (i == 8) bus.req = 8'h40;
      tick(1); lit("rr_gap", 8'h00, 0);
    end

    // Owner 6 releases so ptr=7; bit 7 wins over bit 0, then the scan wraps.
    tick(1); lit("own6", 8'h40, 6);
    bus.req = 8'h00;
    tick(1); lit("own6_rel", 8'h00, 0);
    bus.req = 8'b1000_0001;
    for (int c = 0; c < MaxHold; c++) begin
      tick(1); lit("wrap7", 8'h80, 7);
    end
    tick(1); lit("wrap_gap", 8'h00, 0);
    tick(1); lit("wrap0", 8'h01, 0);
    bus.req = 8'h00;
    tick(1); lit("wrap_rel", 8'h00, 0);

    // Lone persistent requester is re-granted after timeout.
    bus.req = 8'h08;
    for (int c = 0; c < MaxHold; c++) begin
      tick(1); lit("single", 8'h08, 3);
    end
    tick(1); lit("single_gap", 8'h00, 0);
    tick(1); lit("single_again", 8'h08, 3);
    bus.req = 8'h00;
    tick(1); lit("single_rel", 8'h00, 0);

    // arb_en blocks new grants but does not cut an active one.
    bus.arb_en = 1'b0;
    bus.req    = 8'h10;
    for (int c = 0; c < 6; c++) begin
      tick(1); lit("en_off", 8'h00, 0);
    end
    bus.arb_en = 1'b1;
    tick(1); lit("en_on", 8'h10, 4);
    bus.arb_en = 1'b0;
    tick(1); lit("en_drop_keep", 8'h10, 4);
    bus.req = 8'h00;
    tick(1); lit("en_drop_rel", 8'h00, 0);

    // Asynchronous reset mid-grant.
    bus.arb_en = 1'b1;
    bus.req    = 8'h20;
    tick(3); lit("pre_rst", 8'h20, 5);
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(bus.gnt), 32'h0);
    check("async_rst_valid", 32'(bus.gnt_valid), 32'h0);
    tick(1);
    rst_n   = 1'b1;
    bus.req = 8'h21;
    tick(1); lit("post_rst", 8'h01, 0);
    bus.req = 8'h00;
    tick(1); lit("post_rst_rel", 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
